lbdr_dr_fsm: RTL and testbench

// Parametrised next-generation LBDR routing unit for one router input port. Decodes the HEADER flit

---
 rtl/lbdr_dr_fsm.sv | 190 +++++++++++++++++++
 tb/tb_lbdr_dr_fsm.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_dr_fsm.sv
// LBDR routing unit with deroute fallback for one router input port.
// Ports: clk/rst, *_rst config, FIFO head (empty/rd_en/flit_id/dst_addr) -> N/E/W/S/L, busy, err.
module lbdr_dr_fsm #(
  parameter int         X_W     = 2,
  parameter int         Y_W     = 2,
  parameter logic [2:0] HEADER  = 3'b001,
  parameter logic [2:0] PAYLOAD = 3'b010,
  parameter logic [2:0] TAIL    = 3'b100,
  parameter bit         ONE_HOT = 1'b1,
  parameter bit         DR_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           Rxy_rst,
  input  logic [3:0]           Cx_rst,
  input  logic [7:0]           Dr_rst,
  input  logic [X_W+Y_W-1:0]   cur_addr_rst,
  input  logic                 empty,
  input  logic                 rd_en,
  input  logic [2:0]           flit_id,
  input  logic [X_W+Y_W-1:0]   dst_addr,
  output logic                 Nport,
  output logic                 Eport,
  output logic                 Wport,
  output logic                 Sport,
  output logic                 Lport,
  output logic                 route_busy,
  output logic                 route_err
);

  localparam int ADDR_W = X_W + Y_W;

  if (HEADER == PAYLOAD || HEADER == TAIL ||
      PAYLOAD == TAIL) begin : g_bad_ids
    $error("flit_id codes must be distinct");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  // Port vectors are indexed {L,S,W,E,N}; the low four
  // bits share the numbering of Cx and the deroute codes.
  logic [4:0]        port_q, port_d;
  logic              err_q, err_d;
  logic [7:0]        rxy_q;
  logic [3:0]        cx_q;
  logic [7:0]        dr_q;
  logic [ADDR_W-1:0] cur_q;

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic           n1, s1, e1, w1, loc;
  logic [3:0]     min_set, min_sel;
  logic [1:0]     prim, dr_code;
  logic [3:0]     dr_port;
  logic           dr_ok;
  logic [4:0]     route;
  logic           route_ok;
  logic           is_hdr, is_tail;

  assign x_cur = cur_q[X_W-1:0];
  assign y_cur = cur_q[ADDR_W-1:X_W];
  assign x_dst = dst_addr[X_W-1:0];
  assign y_dst = dst_addr[ADDR_W-1:X_W];

  assign n1  = y_dst < y_cur;
  assign s1  = y_cur < y_dst;
  assign e1  = x_cur < x_dst;
  assign w1  = x_dst < x_cur;
  assign loc = ~n1 & ~s1 & ~e1 & ~w1;

  assign min_set[0] = (n1 & ~e1 & ~w1 |
                       n1 & e1 & rxy_q[0] |
                       n1 & w1 & rxy_q[1]) & cx_q[0];
  assign min_set[1] = (e1 & ~n1 & ~s1 |
                       e1 & n1 & rxy_q[2] |
                       e1 & s1 & rxy_q[3]) & cx_q[1];
  assign min_set[2] = (w1 & ~n1 & ~s1 |
                       w1 & n1 & rxy_q[4] |
                       w1 & s1 & rxy_q[5]) & cx_q[2];
  assign min_set[3] = (s1 & ~e1 & ~w1 |
                       s1 & e1 & rxy_q[6] |
                       s1 & w1 & rxy_q[7]) & cx_q[3];

  always_comb begin
    min_sel = min_set;
    if (ONE_HOT) begin
      min_sel = '0;
      priority case (1'b1)
        min_set[0]: min_sel[0] = 1'b1;
        min_set[1]: min_sel[1] = 1'b1;
        min_set[2]: min_sel[2] = 1'b1;
        min_set[3]: min_sel[3] = 1'b1;
        default:    min_sel    = '0;
      endcase
    end
  end

  // Vertical displacement wins the choice of primary
  // direction; its 2-bit slot in Dr picks the detour.
  always_comb begin
    prim = 2'd2;
    priority case (1'b1)
      n1:      prim = 2'd0;
      s1:      prim = 2'd3;
      e1:      prim = 2'd1;
      default: prim = 2'd2;
    endcase
  end

  assign dr_code = dr_q[{prim, 1'b0} +: 2];
  assign dr_port = 4'b0001 << dr_code;
  assign dr_ok   = DR_EN & cx_q[dr_code];

  always_comb begin
    route    = '0;
    route_ok = 1'b1;
    if (loc)
      route = 5'b10000;
    else if (|min_sel)
      route = {1'b0, min_sel};
    else if (dr_ok)
      route = {1'b0, dr_port};
    else
      route_ok = 1'b0;
  end

  assign is_hdr  = flit_id == HEADER;
  assign is_tail = flit_id == TAIL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      err_q   <= 1'b0;
      rxy_q   <= Rxy_rst;
      cx_q    <= Cx_rst;
      dr_q    <= Dr_rst;
      cur_q   <= cur_addr_rst;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (is_hdr && route_ok) begin
            port_d  = route;
            state_d = BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!empty) begin
          if (is_tail && rd_en) begin
            port_d  = '0;
            state_d = IDLE;
          end else if (is_hdr) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        port_d  = '0;
      end
    endcase
  end

  always_comb begin
    Nport      = port_q[0];
    Eport      = port_q[1];
    Wport      = port_q[2];
    Sport      = port_q[3];
    Lport      = port_q[4];
    route_busy = state_q == BUSY;
    route_err  = err_q;
  end

endmodule

// File: tb/tb_lbdr_dr_fsm.sv
// Bench for lbdr_dr_fsm: three variants (one-hot, all-candidates, no-deroute)
// driven in parallel, directed scenarios then random cycles against a reference.
module tb_lbdr_dr_fsm;

  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] PAY = 3'b010;
  localparam logic [2:0] TL  = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxy_rst, dr_rst;
  logic [3:0] cx_rst, cur_rst;
  logic       empty, rd_en;
  logic [2:0] fid;
  logic [3:0] dst;

  logic [2:0][4:0] pt;
  logic [2:0]      bz, er;

  int n_chk  = 0;
  int n_fail = 0;

  bit [7:0] c_rxy, c_dr;
  bit [3:0] c_cx, c_cur;
  bit       m_busy [3];
  bit [4:0] m_port [3];
  bit       m_err  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lbdr_dr_fsm #(
      .ONE_HOT (g != 1),
      .DR_EN   (g != 2)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .Rxy_rst      (rxy_rst),
      .Cx_rst       (cx_rst),
      .Dr_rst       (dr_rst),
      .cur_addr_rst (cur_rst),
      .empty        (empty),
      .rd_en        (rd_en),
      .flit_id      (fid),
      .dst_addr     (dst),
      .Nport        (pt[g][0]),
      .Eport        (pt[g][1]),
      .Wport        (pt[g][2]),
      .Sport        (pt[g][3]),
      .Lport        (pt[g][4]),
      .route_busy   (bz[g]),
      .route_err    (er[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Direction indices: 0 N, 1 E, 2 W, 3 S.
  // Rxy bit allowing direction d when the other
  // productive direction is o.
  function automatic bit turn_ok(int d, int o);
    int b;
    case (d)
      0:       b = (o == 1) ? 0 : 1;
      1:       b = (o == 0) ? 2 : 3;
      2:       b = (o == 0) ? 4 : 5;
      default: b = (o == 1) ? 6 : 7;
    endcase
    return c_rxy[b];
  endfunction

  function automatic bit [4:0] ref_route(input bit oh,
                                         input bit den,
                                         input bit [3:0] d,
                                         output bit ok);
    int xc = int'(c_cur[1:0]);
    int yc = int'(c_cur[3:2]);
    int xd = int'(d[1:0]);
    int yd = int'(d[3:2]);
    int dv, dh, p;
    bit hv, hh;
    bit [1:0] code;
    bit [4:0] r = '0;
    int cand[$];
    ok = 1'b1;
    if (d == c_cur) return 5'h10;
    hv = yd != yc;
    hh = xd != xc;
    dv = (yd < yc) ? 0 : 3;
    dh = (xd > xc) ? 1 : 2;
    if (hv && hh) begin
      if (turn_ok(dv, dh)) cand.push_back(dv);
      if (turn_ok(dh, dv)) cand.push_back(dh);
    end else begin
      cand.push_back(hv ? dv : dh);
    end
    foreach (cand[i])
      if (c_cx[cand[i]]) r[cand[i]] = 1'b1;
    if (r != 0) begin
      if (oh) r = r & (~r + 5'd1);
      return r;
    end
    if (den) begin
      p = hv ? dv : dh;
      code = c_dr[2*p +: 2];
      if (c_cx[code]) return 5'h01 << code;
    end
    ok = 1'b0;
    return 5'h00;
  endfunction

  task automatic model_step();
    bit ok;
    bit [4:0] r;
    for (int i = 0; i < 3; i++) begin
      m_err[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
        m_port[i] = '0;
      end else if (!empty) begin
        if (!m_busy[i]) begin
          if (fid == HDR) begin
            r = ref_route(i != 1, i != 2, dst, ok);
            if (ok) begin
              m_port[i] = r;
              m_busy[i] = 1'b1;
            end else begin
              m_err[i] = 1'b1;
            end
          end else begin
            m_err[i] = 1'b1;
          end
        end else if (fid == TL && rd_en) begin
          m_port[i] = '0;
          m_busy[i] = 1'b0;
        end else if (fid == HDR) begin
          m_err[i] = 1'b1;
        end
      end
    end
    if (rst) begin
      c_rxy = rxy_rst;
      c_cx  = cx_rst;
      c_dr  = dr_rst;
      c_cur = cur_rst;
    end
  endtask

  task automatic drive(input bit r, input bit e,
                       input bit rd, input logic [2:0] f,
                       input logic [3:0] d);
    rst   = r;
    empty = e;
    rd_en = rd;
    fid   = f;
    dst   = d;
    model_step();
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("port%0d", i), 8'(pt[i]), 8'(m_port[i]));
      chk($sformatf("busy%0d", i), 8'(bz[i]), 8'(m_busy[i]));
      chk($sformatf("err%0d", i), 8'(er[i]), 8'(m_err[i]));
    end
  endtask

  task automatic cfg(input logic [7:0] r, input logic [3:0] c,
                     input logic [7:0] d, input logic [3:0] a);
    rxy_rst = r;
    cx_rst  = c;
    dr_rst  = d;
    cur_rst = a;
  endtask

  initial begin
    // 1: local delivery
    cfg(8'h3C, 4'hF, 8'h00, 4'h5);
    drive(1, 1, 0, PAY, 0);
    tick();
    chk("t1_rst_port", 8'(pt[0]), 8'h00);
    chk("t1_rst_busy", 8'(bz[0]), 8'h00);
    drive(0, 0, 0, HDR, 4'h5);
    tick();
    chk("t1_local", 8'(pt[0]), 8'h10);
    chk("t1_busy", 8'(bz[0]), 8'h01);
    drive(0, 0, 1, TL, 0);
    tick();

    // 2: NW destination, one-hot vs all candidates
    cfg(8'h12, 4'hF, 8'h00, 4'h5);
    drive(1, 1, 0, PAY, 0);
    tick();
    drive(0, 0, 0, HDR, 4'h0);
    tick();
    chk("t2_onehot", 8'(pt[0]), 8'h01);
    chk("t2_all", 8'(pt[1]), 8'h05);
    drive(0, 0, 1, TL, 0);
    tick();

    // 3: east link down, deroute to N, then to E (down)
    cfg(8'h3C, 4'b1101, 8'h00, 4'h5);
    drive(1, 1, 0, PAY, 0);
    tick();
    drive(0, 0, 0, HDR, 4'h7);
    tick();
    chk("t3_dr_n", 8'(pt[0]), 8'h01);
    chk("t3_nodr_err", 8'(er[2]), 8'h01);
    chk("t3_nodr_port", 8'(pt[2]), 8'h00);
    drive(0, 0, 1, TL, 0);
    tick();
    cfg(8'h3C, 4'b1101, 8'h04, 4'h5);
    drive(1, 1, 0, PAY, 0);
    tick();
    drive(0, 0, 0, HDR, 4'h7);
    tick();
    chk("t3_dr_err", 8'(er[0]), 8'h01);
    chk("t3_dr_port", 8'(pt[0]), 8'h00);
    chk("t3_dr_busy", 8'(bz[0]), 8'h00);
    drive(0, 1, 0, PAY, 0);
    tick();
    chk("t3_err_once", 8'(er[0]), 8'h00);

    // 4: full packet, empty toggling
    cfg(8'h3C, 4'hF, 8'h00, 4'h5);
    drive(1, 1, 0, PAY, 0);
    tick();
    drive(0, 0, 0, HDR, 4'hF);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, k[0], k[1], PAY, 0);
      tick();
      chk("t4_hold", 8'(pt[0]), 8'h02);
    end
    drive(0, 1, 1, TL, 0);
    tick();
    chk("t4_tail_empty", 8'(pt[0]), 8'h02);
    drive(0, 0, 1, TL, 0);
    tick();
    chk("t4_release", 8'(pt[0]), 8'h00);
    chk("t4_idle", 8'(bz[0]), 8'h00);

    // 5: protocol errors
    drive(0, 0, 0, PAY, 0);
    tick();
    chk("t5_pay_err", 8'(er[0]), 8'h01);
    drive(0, 0, 0, HDR, 4'hF);
    tick();
    drive(0, 0, 0, HDR, 4'h0);
    tick();
    chk("t5_hdr_err", 8'(er[0]), 8'h01);
    chk("t5_hdr_hold", 8'(pt[0]), 8'h02);

    // 6: reset mid-packet with new config
    cfg(8'h3C, 4'b1101, 8'h00, 4'hA);
    drive(1, 0, 0, PAY, 0);
    tick();
    chk("t6_abort", 8'(pt[0]), 8'h00);
    chk("t6_abort_busy", 8'(bz[0]), 8'h00);
    drive(0, 0, 0, HDR, 4'hB);
    tick();
    chk("t6_newcfg", 8'(pt[0]), 8'h01);
    drive(0, 0, 1, TL, 0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int s;
      logic [2:0] f;
      cfg(8'($urandom), ($urandom_range(0, 3) == 0) ?
          4'($urandom) : 4'hF, 8'($urandom), 4'($urandom));
      s = $urandom_range(0, 9);
      if (s < 3)      f = HDR;
      else if (s < 6) f = PAY;
      else if (s < 9) f = TL;
      else            f = 3'($urandom);
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, f, 4'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
